// File: rtl/floo_resp_rob.sv
// floo_resp_rob: response reorder buffer.
//
// Hands out slot tags in order on the alloc port, accepts responses tagged
// with those slots in any order, and releases the payloads in allocation
// order on the out port.
//
// Ports:
//   clk_i, rst_i               single clock, synchronous active-high reset
//   alloc_valid_i/ready_o/idx_o  slot allocation handshake and granted tag
//   rsp_valid_i/ready_o/idx_i/data_i  out-of-order response input (always ready)
//   out_valid_o/ready_i/data_o   in-order response output
//   occupancy_o                allocated, not-yet-released slots
//   err_o                      sticky protocol error flag
//
// Optional feature: define FLOO_RESP_ROB_ERR_CHECK_EN to drop responses that
// target an unallocated or already-filled slot and flag them on err_o.
// Without it every response is written and err_o is tied low.

module floo_resp_rob #(
  parameter int unsigned RobSize   = 8,
  parameter int unsigned DataWidth = 64
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         alloc_valid_i,
  output logic                         alloc_ready_o,
  output logic [$clog2(RobSize)-1:0]   alloc_idx_o,
  input  logic                         rsp_valid_i,
  output logic                         rsp_ready_o,
  input  logic [$clog2(RobSize)-1:0]   rsp_idx_i,
  input  logic [DataWidth-1:0]         rsp_data_i,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic [DataWidth-1:0]         out_data_o,
  output logic [$clog2(RobSize):0]     occupancy_o,
  output logic                         err_o
);

  localparam int unsigned IdxW = $clog2(RobSize);
  localparam int unsigned CntW = IdxW + 1;

  logic [IdxW-1:0]      r_head;
  logic [IdxW-1:0]      r_tail;
  logic [CntW-1:0]      r_count;
  logic [RobSize-1:0]   r_filled;
  logic [DataWidth-1:0] r_mem [RobSize];

  logic                 w_alloc;
  logic                 w_release;
  logic                 w_fill;
  logic                 w_bad;
  logic [RobSize-1:0]   w_filled_d;

  assign alloc_ready_o = (r_count < CntW'(RobSize));
  assign alloc_idx_o   = r_tail;
  assign rsp_ready_o   = 1'b1;
  // Empty guard matters when stale fills linger in unallocated slots.
  assign out_valid_o   = r_filled[r_head] & (r_count != '0);
  assign out_data_o    = r_mem[r_head];
  assign occupancy_o   = r_count;

  assign w_alloc   = alloc_valid_i & alloc_ready_o;
  assign w_release = out_valid_o & out_ready_i;

`ifdef FLOO_RESP_ROB_ERR_CHECK_EN
  logic [IdxW-1:0] w_offset;
  logic            w_in_window;
  logic            r_err;

  // Distance from head modulo RobSize; allocated iff it is below count.
  assign w_offset    = rsp_idx_i - r_head;
  assign w_in_window = ({1'b0, w_offset} < r_count);
  assign w_bad       = rsp_valid_i & (~w_in_window | r_filled[rsp_idx_i]);
  assign err_o       = r_err;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_err <= 1'b0;
    end else if (w_bad) begin
      r_err <= 1'b1;
    end
  end
`else
  assign w_bad = 1'b0;
  assign err_o = 1'b0;
`endif

  assign w_fill = rsp_valid_i & ~w_bad;

  // Release clear is applied after the fill so it wins on the same index.
  always_comb begin
    w_filled_d = r_filled;
    if (w_fill) begin
      w_filled_d[rsp_idx_i] = 1'b1;
    end
    if (w_release) begin
      w_filled_d[r_head] = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_head   <= '0;
      r_tail   <= '0;
      r_count  <= '0;
      r_filled <= '0;
    end else begin
      r_filled <= w_filled_d;
      // Power-of-two size: natural overflow is the wrap.
      if (w_alloc) begin
        r_tail <= r_tail + IdxW'(1);
      end
      if (w_release) begin
        r_head <= r_head + IdxW'(1);
      end
      unique case ({w_alloc, w_release})
        2'b10:   r_count <= r_count + CntW'(1);
        2'b01:   r_count <= r_count - CntW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Payload storage carries no reset; responses during reset are ignored.
  always_ff @(posedge clk_i) begin
    if (!rst_i && w_fill) begin
      r_mem[rsp_idx_i] <= rsp_data_i;
    end
  end

endmodule
